hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter REG_AW, default 5, register-address width.
REQ-002 SHALL have port clk  in  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  in  1  reset, synchronous and active-high.
REQ-004 SHALL have ports id_rs1_addr, id_rs2_addr  in  REG_AW  ID-stage source registers; id_rs1_used, id_rs2_used  in  1  source actually read.
REQ-005 SHALL have ports ex_rd_addr  in  REG_AW, ex_reg_we  in  1, ex_is_load  in  1  instruction in EX.
REQ-006 SHALL have ports wb_rd_addr  in  REG_AW, wb_reg_we  in  1, wb_is_load  in  1  instruction in EX/WB register.
REQ-007 SHALL have ports ex_redirect  in  1  taken branch/jump resolved in EX; dmem_ready  in  1  load data valid.
REQ-008 SHALL have outputs stall_if, stall_id  1  hold PC and IF/ID register; flush_id  1  zero IF/ID; bubble_ex  1  zero EX control (NOP into EX/WB); ex_wb_en  1  EX/WB register load enable.
REQ-009 SHALL have outputs fwd_a_sel, fwd_b_sel  2  operand source: 00 regfile, 01 EX result, 10 WB result; state_o  2  current FSM state.

Function
REQ-010 SHALL implement FSM states RUN=00, LOAD_USE=01, FLUSH=10, MEM_WAIT=11; outputs combinational from state and inputs.
REQ-011 SHALL define mem_hold = wb_is_load & ~dmem_ready; mem_hold has highest priority in every state.
REQ-012 SHALL, while mem_hold: stall_if=stall_id=1, ex_wb_en=0, flush_id=0, bubble_ex=0; next state MEM_WAIT; leave MEM_WAIT to RUN in the cycle after dmem_ready=1.
REQ-013 SHALL define load_use = ex_is_load & ex_reg_we & ex_rd_addr!=0 & ((id_rs1_used & id_rs1_addr==ex_rd_addr) | (id_rs2_used & id_rs2_addr==ex_rd_addr)).
REQ-014 SHALL, in RUN with ex_redirect and no mem_hold: flush_id=1, bubble_ex=1, ex_wb_en=1, no stall; next state FLUSH; redirect wins over load_use.
REQ-015 SHALL, in RUN with load_use (no redirect, no mem_hold): stall_if=stall_id=1, bubble_ex=1, ex_wb_en=1; next state LOAD_USE; exactly one bubble per load-use.
REQ-016 SHALL, in LOAD_USE or FLUSH without mem_hold: all stall/flush/bubble 0, ex_wb_en=1, next state RUN (no re-stall on the stalled instruction).
REQ-017 SHALL, in RUN with no event: all stall/flush/bubble 0, ex_wb_en=1.
REQ-018 SHALL compute fwd_x_sel per source: 01 if ex_reg_we & ~ex_is_load & ex_rd_addr!=0 & match; else 10 if wb_reg_we & wb_rd_addr!=0 & match; else 00; EX beats WB; x0 never forwarded; fwd outputs independent of FSM state.

Reset
REQ-019 SHALL, with rst=1 at a clock edge, set state RUN regardless of current state, including mid-MEM_WAIT.
REQ-020 SHALL drive, while rst=1, stall_if=stall_id=0, flush_id=1, bubble_ex=1, ex_wb_en=1, fwd_a_sel=fwd_b_sel=00, state_o=00.

Configuration
REQ-021 SHALL, with HAZARD_PERF_EN defined, add outputs perf_stall_cnt 32 and perf_flush_cnt 32: increment on each cycle stall_if=1 / flush_id=1, wrap 0xFFFFFFFF->0, clear on rst.
REQ-022 SHALL, without HAZARD_PERF_EN, omit those ports and counters entirely; all other behaviour identical.

Structure
REQ-023 SHALL take state encodings and fwd_sel encodings (FWD_RF, FWD_EX, FWD_WB) from the shared defines include, not local literals.
REQ-024 SHALL place forwarding compare in one sub-module fwd_unit instantiated twice (operand A, B); FSM stays in hazard_ctrl.
REQ-025 SHALL hold state in the codebase's REGISTER_R primitive.

Verification
REQ-026 SHALL cover: ex_is_load=1, ex_rd=5, id_rs1=5 used -> one cycle stall_if=1, bubble_ex=1, state LOAD_USE, then RUN, stall 0.
REQ-027 SHALL cover: ex_redirect=1 same cycle as load_use -> flush_id=1, bubble_ex=1, stall_if=0, next state FLUSH.
REQ-028 SHALL cover: wb_is_load=1, dmem_ready=0 for 3 cycles -> ex_wb_en=0 and stall_if=1 for 3 cycles, MEM_WAIT, RUN after ready.
REQ-029 SHALL cover: ex_rd=wb_rd=7, both we, id_rs2=7 -> fwd_b_sel=01; ex_rd=0, wb_rd=0 -> 00.
REQ-030 SHALL cover: rst=1 during MEM_WAIT -> state RUN next cycle, outputs per REQ-020; with HAZARD_PERF_EN, counters 0.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg: FSM state and forwarding-select encodings shared by the hazard controller.
`default_nettype none

package hazard_ctrl_pkg;

   typedef enum logic [1:0] {
      RUN      = 2'b00,
      LOAD_USE = 2'b01,
      FLUSH    = 2'b10,
      MEM_WAIT = 2'b11
   } state_t;

   localparam int          STATE_W = 2;
   localparam logic [1:0]  FWD_RF  = 2'b00;
   localparam logic [1:0]  FWD_EX  = 2'b01;
   localparam logic [1:0]  FWD_WB  = 2'b10;

endpackage

`default_nettype wire

// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: pipeline <-> hazard controller signal bundle (master = pipeline, slave = controller).
`default_nettype none

interface hazard_ctrl_if #(
   parameter int REG_AW = 5
);
   logic [REG_AW-1:0] id_rs1_addr;
   logic [REG_AW-1:0] id_rs2_addr;
   logic              id_rs1_used;
   logic              id_rs2_used;
   logic [REG_AW-1:0] ex_rd_addr;
   logic              ex_reg_we;
   logic              ex_is_load;
   logic [REG_AW-1:0] wb_rd_addr;
   logic              wb_reg_we;
   logic              wb_is_load;
   logic              ex_redirect;
   logic              dmem_ready;

   logic              stall_if;
   logic              stall_id;
   logic              flush_id;
   logic              bubble_ex;
   logic              ex_wb_en;
   logic [1:0]        fwd_a_sel;
   logic [1:0]        fwd_b_sel;
   logic [1:0]        state_o;

   modport master (
      output id_rs1_addr, id_rs2_addr, id_rs1_used, id_rs2_used,
      output ex_rd_addr, ex_reg_we, ex_is_load,
      output wb_rd_addr, wb_reg_we, wb_is_load,
      output ex_redirect, dmem_ready,
      input  stall_if, stall_id, flush_id, bubble_ex, ex_wb_en,
      input  fwd_a_sel, fwd_b_sel, state_o
   );

   modport slave (
      input  id_rs1_addr, id_rs2_addr, id_rs1_used, id_rs2_used,
      input  ex_rd_addr, ex_reg_we, ex_is_load,
      input  wb_rd_addr, wb_reg_we, wb_is_load,
      input  ex_redirect, dmem_ready,
      output stall_if, stall_id, flush_id, bubble_ex, ex_wb_en,
      output fwd_a_sel, fwd_b_sel, state_o
   );
endinterface

`default_nettype wire

// File: rtl/hazard_ctrl_fwd_unit.sv
// fwd_unit: operand bypass select for one source register; EX result beats WB, x0 never bypassed.
`default_nettype none

module fwd_unit
   import hazard_ctrl_pkg::*;
#(
   parameter int REG_AW = 5
) (
   input  logic [REG_AW-1:0] rs_addr,
   input  logic [REG_AW-1:0] ex_rd_addr,
   input  logic              ex_reg_we,
   input  logic              ex_is_load,
   input  logic [REG_AW-1:0] wb_rd_addr,
   input  logic              wb_reg_we,
   output logic [1:0]        sel
);
   logic ex_hit;
   logic wb_hit;

   // A load in EX has no result yet; that case is covered by the load-use stall.
   assign ex_hit = ex_reg_we & ~ex_is_load & (ex_rd_addr != '0) & (ex_rd_addr == rs_addr);
   assign wb_hit = wb_reg_we & (wb_rd_addr != '0) & (wb_rd_addr == rs_addr);

   always_comb begin
      sel = FWD_RF;
      if (ex_hit)      sel = FWD_EX;
      else if (wb_hit) sel = FWD_WB;
   end
endmodule

`default_nettype wire

// File: rtl/hazard_ctrl_register_r.sv
// register_r: generic D register with synchronous active-high reset to RESET_VAL.
`default_nettype none

module register_r #(
   parameter int               WIDTH     = 1,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);
   always_ff @(posedge clk) begin
      if (rst) q <= RESET_VAL;
      else     q <= d;
   end
endmodule

`default_nettype wire

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline stall/flush/bubble FSM plus operand forwarding selects.
// Optional HAZARD_PERF_EN adds 32-bit stall and flush cycle counters.
`default_nettype none

module hazard_ctrl
   import hazard_ctrl_pkg::*;
#(
   parameter int REG_AW = 5
) (
   input  logic         clk,
   input  logic         rst,
   hazard_ctrl_if.slave bus
`ifdef HAZARD_PERF_EN
   ,
   output logic [31:0]  perf_stall_cnt,
   output logic [31:0]  perf_flush_cnt
`endif
);
   logic [STATE_W-1:0] state_q;
   logic [STATE_W-1:0] state_d;
   state_t             state;
   state_t             next_state;

   logic mem_hold;
   logic load_use;
   logic stall;
   logic flush;
   logic bubble;
   logic wb_en;
   logic [1:0] fwd_a_raw;
   logic [1:0] fwd_b_raw;

   assign mem_hold = bus.wb_is_load & ~bus.dmem_ready;
   assign load_use = bus.ex_is_load & bus.ex_reg_we & (bus.ex_rd_addr != '0) &
                     ((bus.id_rs1_used & (bus.id_rs1_addr == bus.ex_rd_addr)) |
                      (bus.id_rs2_used & (bus.id_rs2_addr == bus.ex_rd_addr)));

   register_r #(
      .WIDTH     (STATE_W),
      .RESET_VAL (RUN)
   ) u_state_reg (
      .clk (clk),
      .rst (rst),
      .d   (state_d),
      .q   (state_q)
   );

   assign state   = state_t'(state_q);
   assign state_d = next_state;

   always_comb begin
      next_state = state;
      stall      = 1'b0;
      flush      = 1'b0;
      bubble     = 1'b0;
      wb_en      = 1'b1;
      if (mem_hold) begin
         // Freeze the whole front of the pipe, including EX/WB, until load data arrives.
         stall      = 1'b1;
         wb_en      = 1'b0;
         next_state = MEM_WAIT;
      end else begin
         unique case (state)
            RUN: begin
               if (bus.ex_redirect) begin
                  flush      = 1'b1;
                  bubble     = 1'b1;
                  next_state = FLUSH;
               end else if (load_use) begin
                  stall      = 1'b1;
                  bubble     = 1'b1;
                  next_state = LOAD_USE;
               end
            end
            LOAD_USE, FLUSH, MEM_WAIT: next_state = RUN;
            default:                   next_state = RUN;
         endcase
      end
   end

   fwd_unit #(.REG_AW(REG_AW)) u_fwd_a (
      .rs_addr    (bus.id_rs1_addr),
      .ex_rd_addr (bus.ex_rd_addr),
      .ex_reg_we  (bus.ex_reg_we),
      .ex_is_load (bus.ex_is_load),
      .wb_rd_addr (bus.wb_rd_addr),
      .wb_reg_we  (bus.wb_reg_we),
      .sel        (fwd_a_raw)
   );

   fwd_unit #(.REG_AW(REG_AW)) u_fwd_b (
      .rs_addr    (bus.id_rs2_addr),
      .ex_rd_addr (bus.ex_rd_addr),
      .ex_reg_we  (bus.ex_reg_we),
      .ex_is_load (bus.ex_is_load),
      .wb_rd_addr (bus.wb_rd_addr),
      .wb_reg_we  (bus.wb_reg_we),
      .sel        (fwd_b_raw)
   );

   // While in reset the pipe is drained with NOPs: flush IF/ID, bubble EX, keep EX/WB loading.
   assign bus.stall_if  = ~rst & stall;
   assign bus.stall_id  = ~rst & stall;
   assign bus.flush_id  =  rst | flush;
   assign bus.bubble_ex =  rst | bubble;
   assign bus.ex_wb_en  =  rst | wb_en;
   assign bus.fwd_a_sel = rst ? FWD_RF : fwd_a_raw;
   assign bus.fwd_b_sel = rst ? FWD_RF : fwd_b_raw;
   assign bus.state_o   = rst ? RUN : state_q;

`ifdef HAZARD_PERF_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         perf_stall_cnt <= '0;
         perf_flush_cnt <= '0;
      end else begin
         if (bus.stall_if) perf_stall_cnt <= perf_stall_cnt + 32'd1;
         if (bus.flush_id) perf_flush_cnt <= perf_flush_cnt + 32'd1;
      end
   end
`endif

endmodule

`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed-vector bench for hazard_ctrl with hand-computed expectations.
`default_nettype none

module tb_hazard_ctrl;
   logic clk;
   logic rst;
   int   vectors;
   int   miscompares;

   hazard_ctrl_if #(.REG_AW(5)) bus ();

`ifdef HAZARD_PERF_EN
   logic [31:0] perf_stall_cnt;
   logic [31:0] perf_flush_cnt;
`endif

   hazard_ctrl #(.REG_AW(5)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
`ifdef HAZARD_PERF_EN
      ,
      .perf_stall_cnt (perf_stall_cnt),
      .perf_flush_cnt (perf_flush_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Checks the five pipeline-control outputs plus the state in one call.
   task automatic chk_ctl(input string tag, input logic [4:0] exp_ctl, input logic [1:0] exp_st);
      chk({tag, " ctl"}, {27'd0, bus.stall_if, bus.stall_id, bus.flush_id, bus.bubble_ex,
                          bus.ex_wb_en}, {27'd0, exp_ctl});
      chk({tag, " state"}, {30'd0, bus.state_o}, {30'd0, exp_st});
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      bus.id_rs1_addr = '0; bus.id_rs2_addr = '0;
      bus.id_rs1_used = 1'b0; bus.id_rs2_used = 1'b0;
      bus.ex_rd_addr  = '0; bus.ex_reg_we  = 1'b0; bus.ex_is_load = 1'b0;
      bus.wb_rd_addr  = '0; bus.wb_reg_we  = 1'b0; bus.wb_is_load = 1'b0;
      bus.ex_redirect = 1'b0; bus.dmem_ready = 1'b1;
   endtask

   // ctl bit order: {stall_if, stall_id, flush_id, bubble_ex, ex_wb_en}
   initial begin
      vectors     = 0;
      miscompares = 0;
      rst = 1'b1;
      clear_inputs();
      // Forwarding-eligible inputs during reset must still produce 00.
      bus.ex_rd_addr = 5'd7; bus.ex_reg_we = 1'b1; bus.id_rs1_addr = 5'd7;
      tick();
      #1;
      chk_ctl("reset", 5'b00111, 2'b00);
      chk("reset fwd_a", {30'd0, bus.fwd_a_sel}, 32'd0);
`ifdef HAZARD_PERF_EN
      chk("reset stall_cnt", perf_stall_cnt, 32'd0);
`endif

      tick();
      rst = 1'b0;
      clear_inputs();
      #1;
      chk_ctl("idle", 5'b00001, 2'b00);

      // Load-use on rs1: one stall/bubble cycle, then no re-stall on the same inputs.
      bus.ex_is_load = 1'b1; bus.ex_reg_we = 1'b1; bus.ex_rd_addr = 5'd5;
      bus.id_rs1_addr = 5'd5; bus.id_rs1_used = 1'b1;
      #1;
      chk_ctl("load_use", 5'b11011, 2'b00);
      chk("load_use fwd_a", {30'd0, bus.fwd_a_sel}, 32'd0);
      tick();
      chk_ctl("load_use held", 5'b00001, 2'b01);
      tick();
      clear_inputs();
      #1;
      chk_ctl("after load_use", 5'b00001, 2'b00);
`ifdef HAZARD_PERF_EN
      chk("stall_cnt after load_use", perf_stall_cnt, 32'd1);
`endif

      // No load-use on x0 or on an unused source.
      bus.ex_is_load = 1'b1; bus.ex_reg_we = 1'b1; bus.ex_rd_addr = 5'd0;
      bus.id_rs1_addr = 5'd0; bus.id_rs1_used = 1'b1;
      #1;
      chk_ctl("load x0", 5'b00001, 2'b00);
      bus.ex_rd_addr = 5'd6; bus.id_rs2_addr = 5'd6; bus.id_rs2_used = 1'b0;
      #1;
      chk_ctl("load rs2 unused", 5'b00001, 2'b00);

      // Redirect coincident with load-use: redirect wins.
      bus.id_rs2_used = 1'b1; bus.ex_redirect = 1'b1;
      #1;
      chk_ctl("redirect", 5'b00111, 2'b00);
      tick();
      bus.ex_redirect = 1'b0;
      #1;
      chk_ctl("flush state", 5'b00001, 2'b10);
      tick();
      clear_inputs();
      #1;
      chk_ctl("after flush", 5'b00001, 2'b00);
`ifdef HAZARD_PERF_EN
      chk("flush_cnt", perf_flush_cnt, 32'd1);
`endif

      // Three cycles of outstanding load data.
      bus.wb_is_load = 1'b1; bus.dmem_ready = 1'b0;
      #1;
      chk_ctl("mem_hold 1", 5'b11000, 2'b00);
      tick();
      chk_ctl("mem_hold 2", 5'b11000, 2'b11);
      tick();
      chk_ctl("mem_hold 3", 5'b11000, 2'b11);
      tick();
      bus.dmem_ready = 1'b1;
      #1;
      chk_ctl("mem ready", 5'b00001, 2'b11);
      tick();
      clear_inputs();
      #1;
      chk_ctl("after mem", 5'b00001, 2'b00);

      // Forwarding priority and x0 exclusion.
      bus.ex_rd_addr = 5'd7; bus.ex_reg_we = 1'b1;
      bus.wb_rd_addr = 5'd7; bus.wb_reg_we = 1'b1;
      bus.id_rs2_addr = 5'd7; bus.id_rs1_addr = 5'd3;
      #1;
      chk("fwd_b ex beats wb", {30'd0, bus.fwd_b_sel}, 32'd1);
      chk("fwd_a no match", {30'd0, bus.fwd_a_sel}, 32'd0);
      bus.ex_is_load = 1'b1;
      #1;
      chk("fwd_b ex load -> wb", {30'd0, bus.fwd_b_sel}, 32'd2);
      bus.ex_is_load = 1'b0; bus.ex_reg_we = 1'b0;
      bus.id_rs1_addr = 5'd7;
      #1;
      chk("fwd_a wb only", {30'd0, bus.fwd_a_sel}, 32'd2);
      bus.ex_reg_we = 1'b1; bus.ex_rd_addr = 5'd0; bus.wb_rd_addr = 5'd0;
      bus.id_rs2_addr = 5'd0;
      #1;
      chk("fwd_b x0", {30'd0, bus.fwd_b_sel}, 32'd0);
      clear_inputs();

      // Reset asserted while in MEM_WAIT.
      bus.wb_is_load = 1'b1; bus.dmem_ready = 1'b0;
      tick();
      chk_ctl("enter mem_wait", 5'b11000, 2'b11);
      rst = 1'b1;
      #1;
      chk_ctl("rst in mem_wait", 5'b00111, 2'b00);
      tick();
`ifdef HAZARD_PERF_EN
      chk("rst stall_cnt", perf_stall_cnt, 32'd0);
      chk("rst flush_cnt", perf_flush_cnt, 32'd0);
`endif
      rst = 1'b0;
      clear_inputs();
      #1;
      chk_ctl("after rst", 5'b00001, 2'b00);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

`default_nettype wire
